// File: rtl/ac97_codec_responder.sv
// rtl/ac97_codec_responder.sv - AC97 codec-side link responder: deframes SYNC/SDATA_OUT,
// keeps a 64x16 shadow register file and answers status reads on SDATA_IN.
module ac97_codec_responder #(
    parameter int READY_FRAMES = 4,
    parameter int FRAME_BITS   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync,
    input  logic        sdata_out,
    output logic        sdata_in,
    output logic        locked,
    output logic        codec_ready,
    output logic        frame_valid,
    output logic [15:0] tag,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right,
    output logic        reg_wr_valid,
    output logic [6:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_error
);

    localparam logic [7:0] LAST_POS  = 8'(FRAME_BITS - 1);
    localparam logic [7:0] READY_CNT = 8'(READY_FRAMES);
    localparam logic [7:0] RX_BITS   = 8'd96;  // tag + slots 1..4
    localparam logic [7:0] TX_BITS   = 8'd56;  // tag + slots 1..2

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t       state_q, state_d;
    logic         sync_q;
    logic [7:0]   bit_pos_q, bit_pos_d;
    logic [95:0]  rx_q, rx_d;
    logic [55:0]  tx_q, tx_d;
    logic         done_q, done_d;
    logic         wr_pend_q, wr_pend_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         sdata_in_q, sdata_in_d;
    logic         err_q, err_d;
    logic [15:0]  tag_q, tag_d;
    logic [19:0]  pcm_l_q, pcm_l_d;
    logic [19:0]  pcm_r_q, pcm_r_d;
    logic [6:0]   wr_addr_q, wr_addr_d;
    logic [15:0]  wr_data_q, wr_data_d;
    logic [15:0]  regs_q [64];

    logic         rise;
    logic         accept;
    logic         take;
    logic [7:0]   pos;
    logic [6:0]   rx_addr;
    logic         is_rd;
    logic         is_wr;
    logic [15:0]  rd_data;
    logic [7:0]   cnt_inc;
    logic         ready_next;
    logic         unused_bits;

    assign rise       = sync & ~sync_q;
    // A completed frame is only honoured once the next frame's sync confirms alignment.
    assign accept     = done_q & sync;
    assign rx_addr    = rx_q[78:72];
    assign is_rd      = rx_q[94] & rx_q[79];
    assign is_wr      = rx_q[94] & rx_q[93] & ~rx_q[79] & ~rx_addr[0];
    assign rd_data    = rx_addr[0] ? 16'h0000 : regs_q[rx_addr[6:1]];
    assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign ready_next = (cnt_inc >= READY_CNT);
    assign unused_bits = ^{rx_q[71:60], rx_q[43:40]};

    always_comb begin
        state_d    = state_q;
        bit_pos_d  = bit_pos_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        wr_pend_d  = 1'b0;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        sdata_in_d = 1'b0;
        err_d      = 1'b0;
        tag_d      = tag_q;
        pcm_l_d    = pcm_l_q;
        pcm_r_d    = pcm_r_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        take       = 1'b0;
        pos        = bit_pos_q;

        case (state_q)
            S_HUNT: begin
                if (rise) begin
                    take    = 1'b1;
                    pos     = 8'd0;
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (!sync && bit_pos_q == 8'd0) begin
                    state_d = S_HUNT;
                    cnt_d   = 8'd0;
                    ready_d = 1'b0;
                    tx_d    = '0;
                end else begin
                    take = 1'b1;
                    if (rise && bit_pos_q != 8'd0) begin
                        err_d = 1'b1;
                        pos   = 8'd0;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        if (take) begin
            bit_pos_d = (pos == LAST_POS) ? 8'd0 : pos + 8'd1;
            if (pos < RX_BITS) begin
                rx_d = {rx_q[94:0], sdata_out};
            end
            if (pos == LAST_POS) begin
                done_d    = 1'b1;
                wr_pend_d = is_wr;
                tag_d     = rx_q[95:80];
                cnt_d     = cnt_inc;
                ready_d   = ready_next;
                if (rx_q[92]) pcm_l_d = rx_q[39:20];
                if (rx_q[91]) pcm_r_d = rx_q[19:0];
                if (is_wr) begin
                    wr_addr_d = rx_addr;
                    wr_data_d = rx_q[59:44];
                end
                // Read data is taken before this frame's own write lands.
                tx_d = {ready_next, is_rd, is_rd, 13'd0,
                        is_rd ? {1'b0, rx_addr, 12'h000} : 20'h00000,
                        is_rd ? {rd_data, 4'h0} : 20'h00000};
            end
        end

        if (state_d == S_LOCKED && bit_pos_d < TX_BITS) begin
            sdata_in_d = tx_d[6'd55 - bit_pos_d[5:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HUNT;
            sync_q     <= 1'b0;
            bit_pos_q  <= 8'd0;
            rx_q       <= '0;
            tx_q       <= '0;
            done_q     <= 1'b0;
            wr_pend_q  <= 1'b0;
            cnt_q      <= 8'd0;
            ready_q    <= 1'b0;
            sdata_in_q <= 1'b0;
            err_q      <= 1'b0;
            tag_q      <= '0;
            pcm_l_q    <= '0;
            pcm_r_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync;
            bit_pos_q  <= bit_pos_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            wr_pend_q  <= wr_pend_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            sdata_in_q <= sdata_in_d;
            err_q      <= err_d;
            tag_q      <= tag_d;
            pcm_l_q    <= pcm_l_d;
            pcm_r_q    <= pcm_r_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (accept && wr_pend_q) begin
            regs_q[wr_addr_q[6:1]] <= wr_data_q;
        end
    end

    assign sdata_in     = sdata_in_q;
    assign locked       = (state_q == S_LOCKED);
    assign codec_ready  = ready_q;
    assign frame_valid  = accept;
    assign reg_wr_valid = accept & wr_pend_q;
    assign tag          = tag_q;
    assign pcm_left     = pcm_l_q;
    assign pcm_right    = pcm_r_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign frame_error  = err_q;

endmodule
